// File: rtl/tile_reqmort_drain.sv
// tile_reqmort_drain
//
// Drains the per-tile cache-line request stream into the local L2 bank.
// Accepted requests are held in a small in-order queue. Each line is
// written to the bank as 66-bit beats (only the beats enabled by the
// request's mask, lowest index first) followed by one tag/state write.
// An expunge request becomes a single invalidate instead. Requests whose
// tile coordinates do not match this tile are dropped and counted.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   in_valid      request present (from the FIFO's outen)
//   in_data       528-bit line, beat k = [66k+65:66k]
//   in_addr       37-bit line address, [1:0] = tile X, [3:2] = tile Y
//   in_size       {shared, exclusive, phymsk[39:0]}; phymsk[7:0] = beat mask
//   in_expun      expunge request
//   in_ready      a queue entry is free
//   bank_we       beat write valid, with bank_addr/bank_beat/bank_wdata
//   bank_inv      invalidate valid, with bank_addr
//   tag_we        tag/state write valid, with tag_shared/tag_excl/tag_phy
//   bank_ready    bank accepts the currently asserted write/invalidate
//   busy          FSM active or queue non-empty
//   misroute_cnt  saturating count of dropped requests
module tile_reqmort_drain #(
  parameter int TILE_X = 0,
  parameter int TILE_Y = 0,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [527:0] in_data,
  input  logic [36:0]  in_addr,
  input  logic [41:0]  in_size,
  input  logic         in_expun,
  output logic         in_ready,
  output logic         bank_we,
  output logic [36:0]  bank_addr,
  output logic [2:0]   bank_beat,
  output logic [65:0]  bank_wdata,
  output logic         bank_inv,
  output logic         tag_we,
  output logic         tag_shared,
  output logic         tag_excl,
  output logic [31:0]  tag_phy,
  input  logic         bank_ready,
  output logic         busy,
  output logic [7:0]   misroute_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] TX = 2'(TILE_X);
  localparam logic [1:0] TY = 2'(TILE_Y);

  typedef enum logic [1:0] {IDLE, BEAT, TAG, EXPUN} state_t;

  state_t state, state_next;

  logic [527:0] q_data  [DEPTH];
  logic [36:0]  q_addr  [DEPTH];
  logic [41:0]  q_size  [DEPTH];
  logic         q_expun [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mis_cnt;

  logic [36:0]  addr;
  logic [527:0] data;
  logic [7:0]   mask;
  logic         sh, ex;
  logic [31:0]  phy;
  logic [2:0]   beat;

  logic        accept, tile_ok, push, pop, load, advance, active;
  logic [41:0] head_size;
  logic [7:0]  mask_cleared;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // A misrouted request still completes its handshake but never enters the queue.
  assign active       = !rst;
  assign in_ready     = active && (count != FULL);
  assign accept       = in_valid && in_ready;
  assign tile_ok      = (in_addr[1:0] == TX) && (in_addr[3:2] == TY);
  assign push         = accept && tile_ok;
  assign head_size    = q_size[rd_ptr];
  assign mask_cleared = mask & ~(8'b1 << beat);

  // Next-state decode; the head entry is only popped once its final
  // tag write or invalidate has been accepted by the bank.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load = 1'b1;
          if (q_expun[rd_ptr])            state_next = EXPUN;
          else if (head_size[7:0] == '0)  state_next = TAG;
          else                            state_next = BEAT;
        end
      end
      BEAT: begin
        if (bank_ready) begin
          advance = 1'b1;
          if (mask_cleared == '0) state_next = TAG;
        end
      end
      TAG, EXPUN: begin
        if (bank_ready) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Working registers: loaded from the head in IDLE, then the mask is
  // consumed one beat at a time so the lowest remaining bit is always next.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      data <= '0;
      mask <= '0;
      sh   <= 1'b0;
      ex   <= 1'b0;
      phy  <= '0;
      beat <= '0;
    end else if (load) begin
      addr <= q_addr[rd_ptr];
      data <= q_data[rd_ptr];
      mask <= head_size[7:0];
      sh   <= head_size[41];
      ex   <= head_size[40];
      phy  <= head_size[39:8];
      beat <= lowest_bit(head_size[7:0]);
    end else if (advance) begin
      mask <= mask_cleared;
      beat <= lowest_bit(mask_cleared);
    end
  end

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr]  <= in_data;
      q_addr[wr_ptr]  <= in_addr;
      q_size[wr_ptr]  <= in_size;
      q_expun[wr_ptr] <= in_expun;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating misroute counter.
  always_ff @(posedge clk) begin
    if (rst)                                 mis_cnt <= '0;
    else if (accept && !tile_ok && mis_cnt != 8'hFF) mis_cnt <= mis_cnt + 8'd1;
  end

  // Outputs come from registered state only; rst forces them low while asserted.
  assign bank_we      = active && (state == BEAT);
  assign bank_inv     = active && (state == EXPUN);
  assign tag_we       = active && (state == TAG);
  assign bank_addr    = (active && state != IDLE) ? addr : '0;
  assign bank_beat    = bank_we ? beat : '0;
  assign bank_wdata   = bank_we ? data[int'(beat)*66 +: 66] : '0;
  assign tag_shared   = tag_we && sh;
  assign tag_excl     = tag_we && ex;
  assign tag_phy      = tag_we ? phy : '0;
  assign busy         = active && ((state != IDLE) || (count != '0));
  assign misroute_cnt = active ? mis_cnt : '0;

endmodule
